control_fsm: RTL and testbench

Multicycle main controller for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the control signals for the datapath: PC, instruction register, register file, ALU muxes, memory and the immediate-extender select `ImmSrc`. Instruction fields come from the instruction register. Memory accesses stall on a `mem_ready` handshake.

---
 rtl/ctrl_pkg.sv | 89 ++++++++
 rtl/alu_decoder.sv | 39 +++
 rtl/control_fsm.sv | 178 +++++++++++++++++
 tb/tb_control_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller, immediate extender
// and datapath muxes.
package ctrl_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned OP_W      = 7;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned IMM_W     = 3;
  localparam int unsigned ALUCTL_W  = 3;
  localparam int unsigned MUXSEL_W  = 2;

  // Controller states
  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    LUI      = 4'd9,
    JAL      = 4'd10,
    BRANCH   = 4'd11
  } state_e;

  // ALU operation class requested by the FSM for the ALU decoder
  typedef enum logic [1:0] {
    ALU_CLASS_ADD = 2'd0,
    ALU_CLASS_SUB = 2'd1,
    ALU_CLASS_R   = 2'd2,
    ALU_CLASS_I   = 2'd3
  } alu_class_e;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  // funct3 values the controller cares about
  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_SLT = 3'b010;
  localparam logic [F3_W-1:0] F3_OR  = 3'b110;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;
  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  // Immediate extender select
  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_U = 3'b011;
  localparam logic [IMM_W-1:0] IMM_J = 3'b100;

  // ALU control
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

  // Result mux
  localparam logic [MUXSEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [MUXSEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [MUXSEL_W-1:0] RES_ALURESULT = 2'b10;

  // ALU source A mux
  localparam logic [MUXSEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [MUXSEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [MUXSEL_W-1:0] SRCA_RS1   = 2'b10;
  localparam logic [MUXSEL_W-1:0] SRCA_ZERO  = 2'b11;

  // ALU source B mux
  localparam logic [MUXSEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [MUXSEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [MUXSEL_W-1:0] SRCB_FOUR = 2'b10;

  // True for opcodes the controller can sequence
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's requested operation class plus funct3/funct7b5
// onto an ALUControl code.
//   alu_class  in  - fixed add, fixed sub, R-type or I-ALU decode
//   funct3     in  - instr[14:12]
//   funct7b5   in  - instr[30]
//   ALUControl out - ALU operation (combinational)
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_class_e               alu_class,
  input  logic [F3_W-1:0]          funct3,
  input  logic                     funct7b5,
  output logic [ALUCTL_W-1:0]      ALUControl
);

  logic is_r;

  always_comb begin
    ALUControl = ALU_ADD;
    is_r       = (alu_class == ALU_CLASS_R);
    case (alu_class)
      ALU_CLASS_ADD: ALUControl = ALU_ADD;
      ALU_CLASS_SUB: ALUControl = ALU_SUB;
      ALU_CLASS_R,
      ALU_CLASS_I: begin
        case (funct3)
          // funct7b5 only selects sub for register-register ops; addi stays add
          F3_ADD:  ALUControl = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_OR:   ALUControl = ALU_OR;
          F3_AND:  ALUControl = ALU_AND;
          F3_SLT:  ALUControl = ALU_SLT;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle main controller for the RV32I core. Sequences each instruction
// through fetch/decode/execute/memory/writeback and drives datapath controls.
// Outputs are combinational from the state register plus mem_ready, Zero and
// instruction fields (zero-cycle latency).
//   clk, reset          - rising-edge clock, async active-high reset to FETCH
//   op/funct3/funct7b5  - instruction fields from the IR
//   Zero                - ALU zero flag (branch resolution)
//   mem_ready           - memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//   ALUSrcB, ALUControl, ImmSrc - datapath controls
//   illegal             - unsupported opcode seen in DECODE
module control_fsm
  import ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OP_W-1:0]       op,
  input  logic [F3_W-1:0]       funct3,
  input  logic                  funct7b5,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [MUXSEL_W-1:0]   ResultSrc,
  output logic [MUXSEL_W-1:0]   ALUSrcA,
  output logic [MUXSEL_W-1:0]   ALUSrcB,
  output logic [ALUCTL_W-1:0]   ALUControl,
  output logic [IMM_W-1:0]      ImmSrc,
  output logic                  illegal
);

  state_e     state;
  state_e     next_state;
  alu_class_e alu_class;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Next-state and output decode
  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ImmSrc     = IMM_I;
    alu_class  = ALU_CLASS_ADD;
    illegal    = 1'b0;

    case (state)
      FETCH: begin
        // PC+4 goes straight back to PC as the IR is loaded
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) next_state = DECODE;
      end

      DECODE: begin
        // OldPC + imm precomputes the branch/jump target into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_BRANCH:    next_state = BRANCH;
          OP_JAL:       next_state = JAL;
          OP_LUI:       next_state = LUI;
          default:      next_state = FETCH;
        endcase
        illegal = !op_supported(op);
      end

      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_LW) begin
          ImmSrc     = IMM_I;
          next_state = MEMREAD;
        end else begin
          ImmSrc     = IMM_S;
          next_state = MEMWRITE;
        end
      end

      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end

      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) next_state = FETCH;
      end

      MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end

      EXECUTER: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_class  = ALU_CLASS_R;
        next_state = ALUWB;
      end

      EXECUTEI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_I;
        alu_class  = ALU_CLASS_I;
        next_state = ALUWB;
      end

      LUI: begin
        // zero + U-immediate
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_U;
        next_state = ALUWB;
      end

      ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end

      JAL: begin
        // PC takes the target from ALUOut while OldPC+4 is computed for rd
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALUOUT;
        PCWrite    = 1'b1;
        next_state = ALUWB;
      end

      BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        alu_class = ALU_CLASS_SUB;
        case (funct3)
          F3_BEQ:  PCWrite = Zero;
          F3_BNE:  PCWrite = !Zero;
          default: PCWrite = 1'b0;
        endcase
        next_state = FETCH;
      end

      default: next_state = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class  (alu_class),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,illegal}
  logic [17:0] act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [17:0] o(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [2:0] ac, input logic [2:0] imm,
                                    input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm, ill};
  endfunction

  task automatic add(input string n, input logic [6:0] vop, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy, input logic [17:0] e);
    vec_t v;
    v.op = vop; v.f3 = f3; v.f7 = f7; v.zero = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
    names.push_back(n);
  endtask

  task automatic chk(input string n, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", n, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] vop, input logic [2:0] f3, input logic f7,
                       input logic z, input logic rdy);
    op = vop; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = rdy;
  endtask

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         LU = 7'b0110111, BAD = 7'b1111111;

  logic [17:0] f_go, f_stall, dec_b, dec_j, alu_wb;

  initial begin
    f_go    = o(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0);
    f_stall = o(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0);
    dec_b   = o(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,0);
    dec_j   = o(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b100,0);
    alu_wb  = o(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0);

    // lw with two stall cycles in FETCH and in MEMREAD: 9 cycles
    add("lw_fetch_stall1", LW, 3'b010, 0, 0, 0, f_stall);
    add("lw_fetch_stall2", LW, 3'b010, 0, 0, 0, f_stall);
    add("lw_fetch",        LW, 3'b010, 0, 0, 1, f_go);
    add("lw_decode",       LW, 3'b010, 0, 0, 1, dec_b);
    add("lw_memadr",       LW, 3'b010, 0, 0, 1, o(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
    add("lw_memread_st1",  LW, 3'b010, 0, 0, 0, o(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    add("lw_memread_st2",  LW, 3'b010, 0, 0, 0, o(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    add("lw_memread",      LW, 3'b010, 0, 0, 1, o(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    add("lw_memwb",        LW, 3'b010, 0, 0, 1, o(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000,0));
    // sw with one stall in MEMWRITE
    add("sw_fetch",        SW, 3'b010, 0, 0, 1, f_go);
    add("sw_decode",       SW, 3'b010, 0, 0, 1, dec_b);
    add("sw_memadr",       SW, 3'b010, 0, 0, 1, o(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0));
    add("sw_memwrite_st",  SW, 3'b010, 0, 0, 0, o(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    add("sw_memwrite",     SW, 3'b010, 0, 0, 1, o(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    // sub (mem_ready low in DECODE must not stall)
    add("sub_fetch",       RT, 3'b000, 1, 0, 1, f_go);
    add("sub_decode_nrdy", RT, 3'b000, 1, 0, 0, dec_b);
    add("sub_execr",       RT, 3'b000, 1, 0, 0, o(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    add("sub_aluwb",       RT, 3'b000, 1, 0, 0, alu_wb);
    // slt
    add("slt_fetch",       RT, 3'b010, 0, 0, 1, f_go);
    add("slt_decode",      RT, 3'b010, 0, 0, 1, dec_b);
    add("slt_execr",       RT, 3'b010, 0, 0, 1, o(0,0,0,0,0,2'b00,2'b10,2'b00,3'b101,3'b000,0));
    add("slt_aluwb",       RT, 3'b010, 0, 0, 1, alu_wb);
    // addi with funct7b5=1 is still add
    add("addi_fetch",      IT, 3'b000, 1, 0, 1, f_go);
    add("addi_decode",     IT, 3'b000, 1, 0, 1, dec_b);
    add("addi_execi",      IT, 3'b000, 1, 0, 1, o(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
    add("addi_aluwb",      IT, 3'b000, 1, 0, 1, alu_wb);
    // ori
    add("ori_fetch",       IT, 3'b110, 0, 0, 1, f_go);
    add("ori_decode",      IT, 3'b110, 0, 0, 1, dec_b);
    add("ori_execi",       IT, 3'b110, 0, 0, 1, o(0,0,0,0,0,2'b00,2'b10,2'b01,3'b011,3'b000,0));
    add("ori_aluwb",       IT, 3'b110, 0, 0, 1, alu_wb);
    // beq taken
    add("beq_fetch",       BR, 3'b000, 0, 1, 1, f_go);
    add("beq_decode",      BR, 3'b000, 0, 1, 1, dec_b);
    add("beq_branch",      BR, 3'b000, 0, 1, 1, o(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    // bne with Zero=1: not taken
    add("bne_fetch",       BR, 3'b001, 0, 1, 1, f_go);
    add("bne_decode",      BR, 3'b001, 0, 1, 1, dec_b);
    add("bne_branch_z1",   BR, 3'b001, 0, 1, 1, o(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    // bne with Zero=0: taken
    add("bne0_fetch",      BR, 3'b001, 0, 0, 1, f_go);
    add("bne0_decode",     BR, 3'b001, 0, 0, 1, dec_b);
    add("bne_branch_z0",   BR, 3'b001, 0, 0, 1, o(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    // unsupported branch funct3
    add("blt_fetch",       BR, 3'b100, 0, 1, 1, f_go);
    add("blt_decode",      BR, 3'b100, 0, 1, 1, dec_b);
    add("blt_branch",      BR, 3'b100, 0, 1, 1, o(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    // jal
    add("jal_fetch",       JL, 3'b000, 0, 0, 1, f_go);
    add("jal_decode",      JL, 3'b000, 0, 0, 1, dec_j);
    add("jal_jal",         JL, 3'b000, 0, 0, 1, o(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b000,0));
    add("jal_aluwb",       JL, 3'b000, 0, 0, 1, alu_wb);
    // lui
    add("lui_fetch",       LU, 3'b000, 0, 0, 1, f_go);
    add("lui_decode",      LU, 3'b000, 0, 0, 1, dec_b);
    add("lui_lui",         LU, 3'b000, 0, 0, 1, o(0,0,0,0,0,2'b00,2'b11,2'b01,3'b000,3'b011,0));
    add("lui_aluwb",       LU, 3'b000, 0, 0, 1, alu_wb);
    // illegal opcode: one DECODE cycle, then back to FETCH
    add("ill_fetch",       BAD, 3'b000, 0, 0, 1, f_go);
    add("ill_decode",      BAD, 3'b000, 0, 0, 1, o(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,1));
    add("ill_next_fetch",  BAD, 3'b000, 0, 0, 1, f_go);
    add("ill_next_decode", BAD, 3'b000, 0, 0, 1, o(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,1));
    add("after_ill_fetch", RT, 3'b000, 0, 0, 0, f_stall);

    // Reset state
    reset = 1'b1;
    drive(RT, 3'b000, 0, 0, 1);
    #1 chk("reset_fetch_rdy1", f_go);
    mem_ready = 1'b0;
    #1 chk("reset_fetch_rdy0", f_stall);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero, vecs[i].rdy);
      #1 chk(names[i], vecs[i].exp);
      @(posedge clk); #1;
    end

    // Reset asserted mid-MEMWRITE while the store is stalled
    drive(SW, 3'b010, 0, 0, 1);
    @(posedge clk); #1;                       // FETCH -> DECODE
    @(posedge clk); #1;                       // DECODE -> MEMADR
    @(posedge clk); #1;                       // MEMADR -> MEMWRITE
    mem_ready = 1'b0;
    #1 chk("rst_pre_memwrite", o(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    reset = 1'b1;
    #1 chk("rst_async_drop_memwrite", f_stall);
    @(posedge clk); #1;
    chk("rst_held_fetch", f_stall);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1 chk("rst_release_fetch", f_go);
    @(posedge clk); #1;
    chk("rst_release_decode", dec_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
